// File: rtl/riscv_fetch_pkg.sv
// Shared types and helpers for the fetch PC generation stage.
package riscv_fetch_pkg;

  localparam int unsigned INSN_BYTES = 4;

  // Bookkeeping for one accepted-but-unreturned imem request.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] target;
    logic        epoch;
  } fetch_meta_t;

  // One fetch-queue entry handed to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        pred_taken;
    logic [31:0] target;
  } fq_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // Data array write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; flush discards everything at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generation: predictor lookup, imem request issue, outstanding
// tracking and fetch queue with redirect-driven wrong-path discard.
module fetch_pc_gen
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bp_addr,
  input  logic        bp_hit,
  input  logic        bp_taken,
  input  logic [31:0] bp_paddr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fq_valid,
  input  logic        fq_ready,
  output logic [31:0] fq_pc,
  output logic [31:0] fq_insn,
  output logic        fq_pred_taken,
  output logic [31:0] fq_pred_target
);

  localparam int unsigned MCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCW = $clog2(FQ_DEPTH + 1);

  logic [31:0]    pc;
  logic           epoch;
  logic [MCW-1:0] stale;
  logic           pred_taken;
  logic [31:0]    next_pc;
  logic           accept;

  fetch_meta_t    meta_in;
  fetch_meta_t    meta_out;
  logic           meta_full;
  logic           meta_empty;
  logic [MCW-1:0] meta_count;

  fq_entry_t      fq_in;
  fq_entry_t      fq_out;
  logic           fq_push;
  logic           fq_pop;
  logic           fq_full;
  logic           fq_empty;
  logic [FCW-1:0] fq_count;
  logic           unused_flags;

  assign bp_addr       = pc;
  assign imem_req_addr = pc;
  assign pred_taken    = bp_hit && bp_taken;
  assign next_pc       = pred_taken ? align_pc(bp_paddr) : pc + 32'(INSN_BYTES);

  // Credit: every accepted request is guaranteed a fetch-queue slot.
  assign imem_req_valid = !rst && !redirect && !meta_full &&
                          ((32'(meta_count) + 32'(fq_count)) < FQ_DEPTH);
  assign accept         = imem_req_valid && imem_req_ready;

  assign meta_in = '{pc: pc, pred_taken: pred_taken, target: next_pc, epoch: epoch};

  // A one-bit epoch aliases after two redirects with requests still in
  // flight; the stale count drops exactly those requests regardless.
  assign fq_push = imem_resp_valid && !redirect && (stale == '0) && (meta_out.epoch == epoch);
  assign fq_pop  = !fq_empty && fq_ready;
  assign fq_in   = '{pc: meta_out.pc, insn: imem_resp_data,
                     pred_taken: meta_out.pred_taken, target: meta_out.target};

  assign fq_valid       = !fq_empty;
  assign fq_pc          = fq_out.pc;
  assign fq_insn        = fq_out.insn;
  assign fq_pred_taken  = fq_out.pred_taken;
  assign fq_pred_target = fq_out.target;

  assign unused_flags = fq_full | meta_empty;

  // PC and epoch: redirect wins, otherwise advance only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      epoch <= 1'b0;
    end else if (redirect) begin
      pc    <= align_pc(redirect_pc);
      epoch <= ~epoch;
    end else if (accept) begin
      pc    <= next_pc;
    end
  end

  // Count of in-flight requests issued before the latest redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      stale <= '0;
    end else if (redirect) begin
      stale <= meta_count - MCW'(imem_resp_valid);
    end else if (imem_resp_valid && (stale != '0)) begin
      stale <= stale - MCW'(1);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_meta_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_meta_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (meta_in),
    .pop       (imem_resp_valid),
    .flush     (1'b0),
    .pop_data  (meta_out),
    .full      (meta_full),
    .empty     (meta_empty),
    .count     (meta_count)
  );

  sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (fq_push),
    .push_data (fq_in),
    .pop       (fq_pop),
    .flush     (redirect),
    .pop_data  (fq_out),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count)
  );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized scoreboard bench for fetch_pc_gen against a generation-count
// reference model of the fetch pipeline.
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bp_addr;
  logic        bp_hit = 1'b0, bp_taken = 1'b0;
  logic [31:0] bp_paddr = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        fq_valid;
  logic        fq_ready = 1'b0;
  logic [31:0] fq_pc, fq_insn, fq_pred_target;
  logic        fq_pred_taken;

  fetch_pc_gen #(
    .RESET_PC        (RST_PC),
    .FQ_DEPTH        (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bp_addr         (bp_addr),
    .bp_hit          (bp_hit),
    .bp_taken        (bp_taken),
    .bp_paddr        (bp_paddr),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fq_valid        (fq_valid),
    .fq_ready        (fq_ready),
    .fq_pc           (fq_pc),
    .fq_insn         (fq_insn),
    .fq_pred_taken   (fq_pred_taken),
    .fq_pred_target  (fq_pred_target)
  );

  always #5 clk = ~clk;

  // Reference model: a request survives only if no redirect happened
  // between its acceptance and its response (tracked by generation number).
  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
    int          gen;
    int          acc;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        pred;
    logic [31:0] tgt;
  } fq_t;

  req_t        mem_q[$];
  fq_t         exp_fq[$];
  logic [31:0] m_pc = RST_PC;
  int          m_gen = 0;
  int          cyc = 0;
  bit          live = 0;

  int n_checks = 0;
  int n_pass   = 0;

  int p_redir = 0, p_hit = 0, p_ready = 100, p_resp = 100, p_fqr = 100;
  bit do_rst = 1, force_redir = 0;
  logic [31:0] force_rpc = '0;

  bit          s_rst = 0, s_redir = 0, s_acc = 0, s_resp = 0;
  logic [31:0] s_rpc = '0;
  req_t        s_req;
  req_t        r_tmp;
  fq_t         e_tmp;
  bit          exp_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Stimulus driver and reference-model update, one pass per clock.
  initial begin : driver
    forever begin
      @(posedge clk);
      if (s_rst) begin
        mem_q.delete();
        exp_fq.delete();
        m_pc  = RST_PC;
        m_gen = 0;
        live  = 1;
      end else if (live) begin
        if (s_resp) begin
          r_tmp = mem_q.pop_front();
          if (!s_redir && r_tmp.gen == m_gen)
            exp_fq.push_back('{pc: r_tmp.pc, insn: r_tmp.data, pred: r_tmp.pred, tgt: r_tmp.tgt});
        end
        if (s_acc) mem_q.push_back(s_req);
        if (s_redir) begin
          exp_fq.delete();
          m_gen++;
          m_pc = s_rpc & ~32'h3;
        end else if (s_acc) begin
          m_pc = s_req.tgt;
        end
      end
      cyc++;

      #2;
      rst = do_rst;
      if (do_rst || !live) begin
        redirect = 0; bp_hit = 0; bp_taken = 0; imem_req_ready = 0;
        imem_resp_valid = 0; fq_ready = 0;
      end else begin
        redirect    = force_redir || pct(p_redir);
        redirect_pc = force_redir ? force_rpc : (32'h0000_3000 | ($urandom & 32'hFFF));
        force_redir = 0;
        bp_hit      = pct(p_hit);
        bp_taken    = pct(50);
        bp_paddr    = 32'h0000_2000 | ($urandom & 32'hFFF);
        imem_req_ready  = pct(p_ready);
        imem_resp_valid = (mem_q.size() > 0) && (mem_q[0].acc < cyc) && pct(p_resp);
        imem_resp_data  = imem_resp_valid ? mem_q[0].data : $urandom;
        fq_ready        = pct(p_fqr);
      end

      #1;
      if (rst) begin
        chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
        s_rst = 1; s_redir = 0; s_acc = 0; s_resp = 0;
      end else if (live) begin
        exp_v = !redirect && (mem_q.size() < 2) && (mem_q.size() + exp_fq.size() < 4);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_v));
        chk("bp_addr", bp_addr, m_pc);
        if (exp_v) chk("req_addr", imem_req_addr, m_pc);
        s_rst   = 0;
        s_redir = redirect;
        s_rpc   = redirect_pc;
        s_resp  = imem_resp_valid;
        s_acc   = exp_v && imem_req_ready;
        if (s_acc) begin
          s_req.pc   = m_pc;
          s_req.pred = bp_hit && bp_taken;
          s_req.tgt  = s_req.pred ? (bp_paddr & ~32'h3) : m_pc + 32'd4;
          s_req.gen  = m_gen;
          s_req.acc  = cyc;
          s_req.data = $urandom;
        end
      end
    end
  end

  // Monitor: compares the fetch-queue head against the scoreboard on pops.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (live && !rst) begin
        chk("fq_valid", 32'(fq_valid), 32'(exp_fq.size() > 0));
        if (exp_fq.size() > 0 && fq_ready) begin
          e_tmp = exp_fq.pop_front();
          chk("fq_pc", fq_pc, e_tmp.pc);
          chk("fq_insn", fq_insn, e_tmp.insn);
          chk("fq_pred_taken", 32'(fq_pred_taken), 32'(e_tmp.pred));
          chk("fq_pred_target", fq_pred_target, e_tmp.tgt);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Phase sequencing through the knobs read by the driver.
  initial begin : sequencer
    do_rst = 1;
    run(3);
    do_rst = 0;
    // sequential fetch, no prediction, 1-cycle memory
    p_redir = 0; p_hit = 0; p_ready = 100; p_resp = 100; p_fqr = 100;
    run(20);
    // predictor hits
    p_hit = 50;
    run(40);
    // redirect stress with slow memory, back-to-back redirects likely
    p_redir = 30; p_resp = 40; p_hit = 30; p_fqr = 70;
    run(400);
    // backpressure then release
    p_redir = 0; p_fqr = 0; p_resp = 80;
    run(30);
    p_fqr = 100;
    run(20);
    // address wrap at the top of memory
    p_hit = 0; p_resp = 100; p_ready = 100;
    force_rpc = 32'hFFFF_FFF6; force_redir = 1;
    run(20);
    // mixed random traffic
    p_redir = 8; p_hit = 35; p_ready = 70; p_resp = 60; p_fqr = 60;
    run(3000);
    // reset mid-operation
    do_rst = 1;
    run(2);
    do_rst = 0;
    p_redir = 20; p_resp = 50;
    run(500);
    // drain
    p_redir = 0; p_ready = 0; p_resp = 100; p_fqr = 100;
    run(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
